farm_sensor: RTL
================

# farm_sensor

Farm-road vehicle detector and queue tracker that produces the `sen` request consumed by the highway/farm-road traffic controller. It observes the controller's `farmroad` light code and cars arriving on the farm-road loop. It keeps a saturating count of waiting vehicles, retiring them at a fixed rate while the farm road is green, and holds `sen` high while vehicles are waiting. It sits between the loop-detector input pin and the traffic controller's `sen` input, clocked on the same `clk` edge as the controller.

## Interface
- `Q_W`, 4: queue counter width; `QUEUE_MAX` = 2^Q_W − 1.
- `DEPART_CYCLES`, 2: farm-green clock cycles per departing vehicle (≥1).
- `SEN_THRESH`, 1: minimum queue count that asserts `sen` (1..QUEUE_MAX).
- `clk`  in  1  system clock; all state updates on the falling edge, matching the traffic controller.
- `reset`  in  1  asynchronous, active-low reset.
- `car_in`  in  1  raw loop-detector level, asynchronous to `clk`; one rising edge = one car.
- `farmroad`  in  3  light code from the controller: 3'b001 red, 3'b010 green, 3'b011 yellow.
- `sen`  out  1  registered request: 1 while queue ≥ SEN_THRESH.
- `queue`  out  Q_W  current waiting-vehicle count.
- `overflow`  out  1  sticky: an arrival was dropped at QUEUE_MAX.
- `code_err`  out  1  sticky: an illegal `farmroad` code was sampled.

## Operation
- Reset (reset=0, asynchronous): `queue`=0, `sen`=0, `overflow`=0, `code_err`=0, synchronizer flops=0, depart timer=0. All outputs hold these values while reset is low.
- Arrival path: `car_in` passes through a 2-flop synchronizer, then a third flop for edge detection. `arrive` = sync2 & ~sync3 produces exactly one pulse per low→high transition. Holding `car_in` high counts once only.
- Departure timer, states IDLE and COUNT:
  - IDLE while `farmroad` ≠ 3'b010 or queue=0; timer held at 0.
  - COUNT while green and queue>0; timer increments each edge.
  - When timer = DEPART_CYCLES−1, `depart` pulses for that edge and the timer returns to 0.
  - Leaving green (yellow, red, or illegal code) forces the timer to 0 immediately. Partial counts are discarded.
- Queue update at each edge:
  - arrive & ~depart: +1, saturating at QUEUE_MAX. An arrival at QUEUE_MAX leaves the queue unchanged and sets `overflow`.
  - depart & ~arrive: −1. `depart` is never generated at queue=0, so no underflow.
  - arrive & depart: unchanged. This case does not set `overflow`, even at QUEUE_MAX.
- `sen` is registered from the next-state queue value (next_queue ≥ SEN_THRESH), so `sen` and `queue` change on the same edge.
- `code_err` is set on any edge that samples `farmroad` ∉ {001, 010, 011}. Illegal codes are treated as not-green: no departures. Arrivals still count.
- `overflow` and `code_err` clear only on reset.

## Timing
- `car_in` first sampled high at edge E0: sync1=1 after E0, sync2=1 after E1, `queue` increments at E2. Latency is 3 edges including E0.
- A `car_in` pulse must be high and low for ≥2 clk periods each to be guaranteed counted.
- Green first sampled at edge G1 with queue>0 and DEPART_CYCLES=2: decrements occur at G2, G4, G6, and so on. With DEPART_CYCLES=1, the queue decrements on every green edge starting at G1.
- `farmroad` changes on the same falling edge as this block samples it. The value registered is the one present before the edge, giving 1-cycle observation latency relative to the controller's state.
- Reset asserted mid-operation clears everything asynchronously. The first arrival after release needs the full 3-edge latency.

## Test plan
- Reset mid-run: queue=5, sen=1, overflow=1; drop reset → queue=0, sen=0, overflow=0, code_err=0 without a clock edge.
- Farmroad red, three `car_in` pulses 6 cycles apart → queue 1, 2, 3, each 3 edges after its rising edge. `sen` rises with queue=1. Holding `car_in` high for 20 cycles adds only 1.
- Queue=3, farmroad switched to green, DEPART_CYCLES=2 → queue 2, 1, 0 at green edges 2, 4, 6. `sen`=0 on the same edge queue reaches 0. The timer stays 0 afterwards.
- Queue=2, green; arrival pulse aligned so `arrive` and `depart` coincide → queue stays 2 that edge. Green→yellow after 1 green edge → no decrement, timer cleared.
- 16 arrivals with Q_W=4, farm red → queue=15 and overflow=1 after the 16th. Then green for 30 cycles → queue=0, overflow still 1.
- farmroad=3'b111 for one edge with queue=4 → code_err=1, queue stays 4. Returning to 3'b010 resumes departures; code_err remains 1.

Source files
------------

// File: rtl/farm_sensor.sv
// farm_sensor
// Farm-road vehicle detector and queue tracker feeding the traffic
// controller's `sen` request. Cars on the loop detector are synchronized
// and edge-detected, and counted into a saturating queue. While the farm road
// is green, one vehicle is retired every DEPART_CYCLES clock edges.
// All state changes on the falling clock edge, the same edge the controller uses.
//
// Ports:
//   clk       in   system clock (state updates on negedge)
//   reset     in   asynchronous active-low reset
//   car_in    in   raw loop-detector level (asynchronous); one rising edge = one car
//   farmroad  in   [2:0] controller light code: 001 red, 010 green, 011 yellow
//   sen       out  registered request, high while queue >= SEN_THRESH
//   queue     out  [Q_W-1:0] waiting-vehicle count
//   overflow  out  sticky flag: an arrival was dropped at QUEUE_MAX
//   code_err  out  sticky flag: an illegal farmroad code was sampled
module farm_sensor #(
    parameter int Q_W           = 4,
    parameter int DEPART_CYCLES = 2,
    parameter int SEN_THRESH    = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           car_in,
    input  logic [2:0]     farmroad,
    output logic           sen,
    output logic [Q_W-1:0] queue,
    output logic           overflow,
    output logic           code_err
);
    localparam int T_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [T_W-1:0] TIMER_LAST = T_W'(DEPART_CYCLES - 1);
    localparam logic [T_W-1:0] TIMER_ZERO = {T_W{1'b0}};
    localparam logic [T_W-1:0] TIMER_ONE  = T_W'(1);
    localparam logic [Q_W-1:0] QUEUE_MAX  = {Q_W{1'b1}};
    localparam logic [Q_W-1:0] QUEUE_ZERO = {Q_W{1'b0}};
    localparam logic [Q_W-1:0] QUEUE_ONE  = Q_W'(1);
    localparam logic [Q_W-1:0] SEN_LEVEL  = Q_W'(SEN_THRESH);
    localparam logic [2:0]     FR_RED     = 3'b001;
    localparam logic [2:0]     FR_GREEN   = 3'b010;
    localparam logic [2:0]     FR_YELLOW  = 3'b011;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } dep_state_t;

    // Only the three light codes the controller can legitimately drive.
    function automatic logic is_legal_code(input logic [2:0] code);
        logic legal;
        case (code)
            FR_RED, FR_GREEN, FR_YELLOW: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic           sync1_r, sync2_r, sync3_r;
    logic           arrive_s;
    dep_state_t     state_r, next_state_s;
    logic [T_W-1:0] timer_r, next_timer_s;
    logic           depart_s;
    logic           go_s;
    logic [Q_W-1:0] queue_r, next_queue_s;
    logic           set_ovf_s;
    logic           sen_r, overflow_r, code_err_r;

    // Two-flop synchronizer plus a third flop for rising-edge detection of car_in.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= car_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign arrive_s = sync2_r & ~sync3_r;

    // Departures only run on a legal green with someone waiting; an illegal
    // code is therefore not-green and halts the timer like yellow/red.
    assign go_s = (farmroad == FR_GREEN) && (queue_r != QUEUE_ZERO);

    // Departure timer state and count register.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            timer_r <= TIMER_ZERO;
        end else begin
            state_r <= next_state_s;
            timer_r <= next_timer_s;
        end
    end

    // Departure timer next state; leaving green discards any partial count.
    always_comb begin
        next_state_s = IDLE;
        next_timer_s = TIMER_ZERO;
        depart_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    next_state_s = COUNT;
                    // Timer is 0 in IDLE, so only a one-cycle period departs at once.
                    if (TIMER_LAST == TIMER_ZERO) begin
                        depart_s     = 1'b1;
                        next_timer_s = TIMER_ZERO;
                    end else begin
                        next_timer_s = TIMER_ONE;
                    end
                end else begin
                    next_state_s = IDLE;
                    next_timer_s = TIMER_ZERO;
                end
            end
            COUNT: begin
                if (go_s) begin
                    next_state_s = COUNT;
                    if (timer_r == TIMER_LAST) begin
                        depart_s     = 1'b1;
                        next_timer_s = TIMER_ZERO;
                    end else begin
                        next_timer_s = timer_r + TIMER_ONE;
                    end
                end else begin
                    next_state_s = IDLE;
                    next_timer_s = TIMER_ZERO;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_timer_s = TIMER_ZERO;
                depart_s     = 1'b0;
            end
        endcase
    end

    // Queue next value; a simultaneous arrival and departure cancel out and
    // never count as an overflow.
    always_comb begin
        next_queue_s = queue_r;
        set_ovf_s    = 1'b0;
        if (arrive_s && !depart_s) begin
            if (queue_r == QUEUE_MAX) begin
                set_ovf_s = 1'b1;
            end else begin
                next_queue_s = queue_r + QUEUE_ONE;
            end
        end else if (depart_s && !arrive_s) begin
            next_queue_s = queue_r - QUEUE_ONE;
        end else begin
            next_queue_s = queue_r;
        end
    end

    // Queue, request and sticky status registers; sen tracks next_queue so it
    // moves on the same edge as queue.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            queue_r    <= QUEUE_ZERO;
            sen_r      <= 1'b0;
            overflow_r <= 1'b0;
            code_err_r <= 1'b0;
        end else begin
            queue_r    <= next_queue_s;
            sen_r      <= (next_queue_s >= SEN_LEVEL);
            overflow_r <= overflow_r | set_ovf_s;
            code_err_r <= code_err_r | ~is_legal_code(farmroad);
        end
    end

    assign queue    = queue_r;
    assign sen      = sen_r;
    assign overflow = overflow_r;
    assign code_err = code_err_r;

endmodule
